// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT output path: bin/magnitude types and
// the streamer control states.
package fft_pkg;

  localparam int D_WIDTH     = 64;
  localparam int LOG_2_WIDTH = 6;
  localparam int MAG_WIDTH   = 17;

  typedef logic signed [15:0]   bin_t;
  typedef logic [MAG_WIDTH-1:0] mag_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/approx_magnitude.sv
// Alpha-max-beta-min magnitude estimate: max(|re|,|im|) + min/4 + min/8.
module approx_magnitude #(
  parameter int MAG_WIDTH = fft_pkg::MAG_WIDTH
) (
  input  logic signed [15:0]    re,
  input  logic signed [15:0]    im,
  output logic [MAG_WIDTH-1:0]  mag
);

  logic [15:0] a, b, mx, mn;

  // Negating -32768 wraps to 16'h8000, which read unsigned is exactly 32768.
  always_comb begin
    a   = re[15] ? $unsigned(-re) : $unsigned(re);
    b   = im[15] ? $unsigned(-im) : $unsigned(im);
    mx  = (a > b) ? a : b;
    mn  = (a > b) ? b : a;
    mag = MAG_WIDTH'(mx) + MAG_WIDTH'(mn >> 2) + MAG_WIDTH'(mn >> 3);
  end

endmodule

// File: rtl/fft_bin_streamer.sv
// Captures a full FFT frame on the done edge, streams one bin per beat with an
// approximate magnitude, then reports the peak-magnitude bin once per frame.
module fft_bin_streamer
  import fft_pkg::bin_t, fft_pkg::state_t, fft_pkg::IDLE, fft_pkg::STREAM, fft_pkg::REPORT;
#(
  parameter int D_WIDTH     = fft_pkg::D_WIDTH,
  parameter int LOG_2_WIDTH = fft_pkg::LOG_2_WIDTH,
  parameter int MAG_WIDTH   = fft_pkg::MAG_WIDTH,
  parameter int SKIP_DC     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [16*D_WIDTH-1:0]  binRe,
  input  logic [16*D_WIDTH-1:0]  binIm,
  input  logic                   fftDone,
  output logic                   busy,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [LOG_2_WIDTH-1:0] outIndex,
  output logic [15:0]            outRe,
  output logic [15:0]            outIm,
  output logic [MAG_WIDTH-1:0]   outMag,
  output logic                   outLast,
  output logic                   peakValid,
  output logic [LOG_2_WIDTH-1:0] peakIndex,
  output logic [MAG_WIDTH-1:0]   peakMag,
  output logic                   overrun
);

  localparam logic [LOG_2_WIDTH-1:0] LAST_IDX   = LOG_2_WIDTH'(D_WIDTH - 1);
  localparam logic [LOG_2_WIDTH-1:0] FIRST_CAND = LOG_2_WIDTH'((SKIP_DC != 0) ? 1 : 0);

  state_t                 state;
  logic [LOG_2_WIDTH-1:0] idx;
  logic                   fftDonePrev;
  logic                   doneEdge;
  logic                   xfer;
  bin_t                   bufRe [D_WIDTH];
  bin_t                   bufIm [D_WIDTH];
  logic [MAG_WIDTH-1:0]   curMag;

  assign doneEdge  = fftDone & ~fftDonePrev;
  assign outValid  = (state == STREAM);
  assign busy      = (state != IDLE);
  assign peakValid = (state == REPORT);
  assign xfer      = outValid & outReady;

  assign outIndex = idx;
  assign outRe    = bufRe[idx];
  assign outIm    = bufIm[idx];
  assign outMag   = curMag;
  assign outLast  = outValid && (idx == LAST_IDX);

  approx_magnitude #(.MAG_WIDTH(MAG_WIDTH)) u_mag (
    .re  (bufRe[idx]),
    .im  (bufIm[idx]),
    .mag (curMag)
  );

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      fftDonePrev <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      fftDonePrev <= fftDone;
      overrun     <= doneEdge && (state != IDLE);
      case (state)
        IDLE: begin
          if (doneEdge) begin
            idx   <= '0;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (xfer) begin
            idx <= idx + 1'b1;
            if (idx == LAST_IDX) state <= REPORT;
          end
        end
        REPORT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < D_WIDTH; i++) begin
        bufRe[i] <= '0;
        bufIm[i] <= '0;
      end
    end else if (state == IDLE && doneEdge) begin
      for (int unsigned i = 0; i < D_WIDTH; i++) begin
        bufRe[i] <= binRe[16*i +: 16];
        bufIm[i] <= binIm[16*i +: 16];
      end
    end
  end

  // Peak registers keep the previous report until the first beat of the next frame,
  // which reseeds them with the first candidate bin so ties resolve to the lowest index.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      peakIndex <= '0;
      peakMag   <= '0;
    end else if (xfer) begin
      if (idx == '0) begin
        peakIndex <= FIRST_CAND;
        peakMag   <= (SKIP_DC != 0) ? '0 : curMag;
      end else if (curMag > peakMag) begin
        peakIndex <= idx;
        peakMag   <= curMag;
      end
    end
  end

endmodule

// File: tb/tb_fft_bin_streamer.sv
// Bench for fft_bin_streamer: frame-level queue model checked every cycle plus
// hand-computed expectations for magnitudes, peaks, overrun and reset.
module tb_fft_bin_streamer;

  localparam int N = 64;

  logic              clk;
  logic              rst;
  logic [16*N-1:0]   binRe, binIm;
  logic              fftDone;
  logic              busy, outValid, outReady, outLast, peakValid, overrun;
  logic [5:0]        outIndex, peakIndex;
  logic [15:0]       outRe, outIm;
  logic [16:0]       outMag, peakMag;

  fft_bin_streamer #(
    .D_WIDTH(64), .LOG_2_WIDTH(6), .MAG_WIDTH(17), .SKIP_DC(1)
  ) dut (
    .clk(clk), .rst(rst), .binRe(binRe), .binIm(binIm), .fftDone(fftDone),
    .busy(busy), .outValid(outValid), .outReady(outReady), .outIndex(outIndex),
    .outRe(outRe), .outIm(outIm), .outMag(outMag), .outLast(outLast),
    .peakValid(peakValid), .peakIndex(peakIndex), .peakMag(peakMag), .overrun(overrun)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef struct { int idx; int re; int im; int mag; bit last; } beat_t;
  beat_t q[$];
  bit    mRep, mPrev, mOv;
  int    expPkIdx, expPkMag;

  function automatic int mag_of(int r, int i);
    int a, b, mx, mn;
    a  = (r < 0) ? -r : r;
    b  = (i < 0) ? -i : i;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    return mx + mn / 4 + mn / 8;
  endfunction

  task automatic load_frame();
    beat_t bt;
    expPkIdx = 1;
    expPkMag = -1;
    for (int k = 0; k < N; k++) begin
      bt.idx  = k;
      bt.re   = int'($signed(binRe[16*k +: 16]));
      bt.im   = int'($signed(binIm[16*k +: 16]));
      bt.mag  = mag_of(bt.re, bt.im);
      bt.last = (k == N - 1);
      q.push_back(bt);
      if (k >= 1 && bt.mag > expPkMag) begin
        expPkMag = bt.mag;
        expPkIdx = k;
      end
    end
  endtask

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      mRep  = 1'b0;
      mPrev = 1'b0;
      mOv   = 1'b0;
    end else begin
      bit de, idlePre;
      de      = fftDone && !mPrev;
      mPrev   = fftDone;
      idlePre = (q.size() == 0) && !mRep;
      mOv     = de && !idlePre;
      if (mRep) mRep = 1'b0;
      else if (q.size() != 0) begin
        if (outReady) begin
          void'(q.pop_front());
          if (q.size() == 0) mRep = 1'b1;
        end
      end else if (de) load_frame();
    end
  end

  // ---------------- compare ----------------
  int dutMag [N];
  int beatCount, lastCount, pkCount, ovCount, pkIdxSeen, pkMagSeen;

  always @(posedge clk) begin
    bit qv;
    qv = (q.size() != 0);
    chk("outValid", outValid, qv);
    chk("busy", busy, qv || mRep);
    chk("peakValid", peakValid, mRep);
    chk("overrun", overrun, mOv);
    if (qv) begin
      chk("outIndex", outIndex, q[0].idx);
      chk("outRe", $signed(outRe), q[0].re);
      chk("outIm", $signed(outIm), q[0].im);
      chk("outMag", outMag, q[0].mag);
      chk("outLast", outLast, q[0].last);
    end
    if (mRep) begin
      chk("peakIndex", peakIndex, expPkIdx);
      chk("peakMag", peakMag, expPkMag);
    end
    if (outValid && outReady) begin
      dutMag[outIndex] = int'(outMag);
      beatCount++;
      if (outLast) lastCount++;
    end
    if (peakValid) begin
      pkCount++;
      pkIdxSeen = int'(peakIndex);
      pkMagSeen = int'(peakMag);
    end
    if (overrun) ovCount++;
  end

  // ---------------- stimulus ----------------
  bit readyMode = 1'b0;

  initial begin
    int c = 0;
    outReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (readyMode) begin
        outReady = ((c % 4) == 0) || ((c % 4) == 3);
        c++;
      end else outReady = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bins();
    binRe = '0;
    binIm = '0;
  endtask

  task automatic set_bin(int k, int re, int im);
    binRe[16*k +: 16] = re[15:0];
    binIm[16*k +: 16] = im[15:0];
  endtask

  task automatic clear_counts();
    beatCount = 0; lastCount = 0; pkCount = 0; ovCount = 0;
    pkIdxSeen = -1; pkMagSeen = -1;
    for (int k = 0; k < N; k++) dutMag[k] = -1;
  endtask

  task automatic fire_done(int hold, bit chkLat);
    fftDone = 1'b1;
    tick();
    if (chkLat) begin
      chk("first_beat_valid", outValid, 1);
      chk("first_beat_index", outIndex, 0);
    end
    repeat (hold - 1) tick();
    fftDone = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    bit ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      tick();
      if (!busy && q.size() == 0 && !mRep) ok = 1'b1;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL wait_idle got busy=%0b want idle within %0d cycles", busy, budget);
    end
    repeat (2) tick();
  endtask

  task automatic wait_index(int k, int budget);
    bit ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      tick();
      if (outValid && outIndex == 6'(k)) ok = 1'b1;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL wait_index got idx=%0d want %0d within %0d cycles", outIndex, k, budget);
    end
  endtask

  initial begin
    rst = 1'b1; fftDone = 1'b0; binRe = '0; binIm = '0;
    clear_counts();
    @(negedge clk);
    #1;
    chk("rst_outValid", outValid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_peakValid", peakValid, 0);
    chk("rst_outIndex", outIndex, 0);
    chk("rst_outMag", outMag, 0);
    chk("rst_peakMag", peakMag, 0);
    chk("rst_overrun", overrun, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // single tone at bin 5, sink always ready
    clear_bins(); set_bin(5, 1000, 0); clear_counts();
    fire_done(1, 1'b1);
    wait_idle(200);
    chk("tone_beats", beatCount, 64);
    chk("tone_last_count", lastCount, 1);
    chk("tone_peak_count", pkCount, 1);
    chk("tone_peak_index", pkIdxSeen, 5);
    chk("tone_peak_mag", pkMagSeen, 1000);

    // backpressure 1,0,0,1 on a random frame
    clear_bins();
    for (int k = 0; k < N; k++)
      set_bin(k, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
    clear_counts();
    readyMode = 1'b1;
    fire_done(1, 1'b1);
    wait_idle(400);
    readyMode = 1'b0;
    chk("bp_beats", beatCount, 64);
    chk("bp_last_count", lastCount, 1);

    // magnitude corner cases
    clear_bins();
    set_bin(1, 300, -400); set_bin(2, -32768, -32768); set_bin(3, 0, -7);
    clear_counts();
    fire_done(1, 1'b0);
    wait_idle(200);
    chk("mag_300_m400", dutMag[1], 512);
    chk("mag_min_min", dutMag[2], 45056);
    chk("mag_0_m7", dutMag[3], 7);
    chk("mag_peak_index", pkIdxSeen, 2);
    chk("mag_peak_mag", pkMagSeen, 45056);

    // DC excluded, tie resolves to lowest index
    clear_bins();
    set_bin(0, 20000, 0); set_bin(10, 500, 0); set_bin(20, 500, 0);
    clear_counts();
    fire_done(1, 1'b0);
    wait_idle(200);
    chk("skipdc_peak_index", pkIdxSeen, 10);
    chk("skipdc_peak_mag", pkMagSeen, 500);

    // all-zero frame
    clear_bins(); clear_counts();
    fire_done(1, 1'b0);
    wait_idle(200);
    chk("zero_peak_index", pkIdxSeen, 1);
    chk("zero_peak_mag", pkMagSeen, 0);

    // overrun mid-stream
    clear_bins(); set_bin(40, -700, 250); clear_counts();
    fire_done(1, 1'b0);
    wait_index(30, 100);
    fftDone = 1'b1;
    tick();
    fftDone = 1'b0;
    wait_idle(200);
    chk("ovr_pulses", ovCount, 1);
    chk("ovr_beats", beatCount, 64);
    chk("ovr_peak_index", pkIdxSeen, 40);
    chk("ovr_peak_count", pkCount, 1);

    // done held high for three cycles
    clear_bins(); set_bin(63, 3, 4); clear_counts();
    fire_done(3, 1'b0);
    wait_idle(200);
    repeat (10) tick();
    chk("held_frames", lastCount, 1);
    chk("held_beats", beatCount, 64);
    chk("held_overrun", ovCount, 0);
    chk("held_peak_index", pkIdxSeen, 63);

    // reset mid-stream at idx 20
    clear_bins(); set_bin(7, 123, 0); clear_counts();
    fire_done(1, 1'b0);
    wait_index(20, 100);
    rst = 1'b1;
    #1;
    chk("midrst_outValid", outValid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_peakValid", peakValid, 0);
    chk("midrst_outIndex", outIndex, 0);
    pkCount = 0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (80) tick();
    chk("midrst_no_peak", pkCount, 0);
    chk("midrst_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
